// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared widths and decoded-control bundle for the ID/EX stage
package riscv_pipe_pkg;

  localparam int DATA_W  = 64;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 2;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               branch;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_register_if.sv
// rtl/id_ex_register_if.sv - decode-side inputs, EX-stage copies and stall for the ID/EX register
interface id_ex_register_if #(
  parameter int DATA_W  = riscv_pipe_pkg::DATA_W,
  parameter int REG_AW  = riscv_pipe_pkg::REG_AW,
  parameter int ALUOP_W = riscv_pipe_pkg::ALUOP_W
);

  logic               id_valid;
  logic [DATA_W-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0]  id_rs1, id_rs2, id_rd;
  logic               id_uses_rs1, id_uses_rs2;
  logic               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src;
  logic [ALUOP_W-1:0] id_alu_op;
  logic [3:0]         id_funct;
  logic               flush;

  logic               ex_valid;
  logic [DATA_W-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_AW-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [3:0]         ex_funct;
  logic               hazard_stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_branch, id_alu_src, id_alu_op, id_funct, flush,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src,
           ex_alu_op, ex_funct, hazard_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_branch, id_alu_src, id_alu_op, id_funct, flush,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src,
           ex_alu_op, ex_funct, hazard_stall
  );

endinterface

// File: rtl/id_ex_register_load_use_detect.sv
// rtl/id_ex_register_load_use_detect.sv - combinational load-use stall between EX load and ID consumer
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  output logic              hazard_stall
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never produces a value to wait for
  assign hazard_stall = id_valid && !flush && ex_valid && ex_mem_read &&
                        (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with bubble insertion on flush, load-use or empty ID
module id_ex_register
  import riscv_pipe_pkg::*;
(
  input logic               clk,
  input logic               reset,
  id_ex_register_if.slave   bus
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  stall;
  logic  bubble;

  assign id_ctrl = '{
    reg_write:  bus.id_reg_write,
    mem_read:   bus.id_mem_read,
    mem_write:  bus.id_mem_write,
    mem_to_reg: bus.id_mem_to_reg,
    branch:     bus.id_branch,
    alu_src:    bus.id_alu_src,
    alu_op:     bus.id_alu_op
  };

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .id_valid    (bus.id_valid),
    .flush       (bus.flush),
    .ex_valid    (bus.ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .hazard_stall(stall)
  );

  // flush, a load-use stall and an empty ID slot all collapse to the same bubble
  assign bubble = bus.flush || stall || !bus.id_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_valid    <= 1'b0;
      ex_ctrl         <= CTRL_BUBBLE;
      bus.ex_pc       <= '0;
      bus.ex_rs1_data <= '0;
      bus.ex_rs2_data <= '0;
      bus.ex_imm      <= '0;
      bus.ex_rs1      <= '0;
      bus.ex_rs2      <= '0;
      bus.ex_rd       <= '0;
      bus.ex_funct    <= '0;
    end else if (bubble) begin
      // data and register fields are left stale; only validity and control are squashed
      bus.ex_valid <= 1'b0;
      ex_ctrl      <= CTRL_BUBBLE;
    end else begin
      bus.ex_valid    <= 1'b1;
      ex_ctrl         <= id_ctrl;
      bus.ex_pc       <= bus.id_pc;
      bus.ex_rs1_data <= bus.id_rs1_data;
      bus.ex_rs2_data <= bus.id_rs2_data;
      bus.ex_imm      <= bus.id_imm;
      bus.ex_rs1      <= bus.id_rs1;
      bus.ex_rs2      <= bus.id_rs2;
      bus.ex_rd       <= bus.id_rd;
      bus.ex_funct    <= bus.id_funct;
    end
  end

  assign bus.ex_reg_write  = ex_ctrl.reg_write;
  assign bus.ex_mem_read   = ex_ctrl.mem_read;
  assign bus.ex_mem_write  = ex_ctrl.mem_write;
  assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign bus.ex_branch     = ex_ctrl.branch;
  assign bus.ex_alu_src    = ex_ctrl.alu_src;
  assign bus.ex_alu_op     = ex_ctrl.alu_op;
  assign bus.hazard_stall  = stall;

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - directed self-checking bench for id_ex_register
module tb_id_ex_register;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  id_ex_register_if bus ();

  id_ex_register dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    bus.id_branch = 0; bus.id_alu_src = 0; bus.id_alu_op = '0; bus.id_funct = '0; bus.flush = 0;
  endtask

  task automatic drive_load(input logic [63:0] pc, input logic [4:0] rd, input logic [4:0] rs1);
    idle();
    bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rd = rd; bus.id_uses_rs1 = 1;
    bus.id_imm = 64'h8; bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_alu_src = 1;
  endtask

  task automatic drive_alu(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2);
    idle();
    bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = 5'd20;
    bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2; bus.id_reg_write = 1; bus.id_alu_op = 2'd2; bus.id_funct = 4'h8;
    bus.id_rs1_data = 64'h1111; bus.id_rs2_data = 64'h2222;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 0;
    drive_alu(64'hABCD_0000, 5'd3, 5'd4, 1, 1);
    bus.id_mem_read = 1; bus.id_rd = 5'd3; bus.id_rs1_data = 64'h5555; bus.id_imm = 64'h77;
    tick(); tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got %0b want 0", bus.ex_valid); end
    n_cmp++; if (bus.ex_pc !== 64'h0) begin n_bad++; $display("FAIL reset_ex_pc got %h want 0", bus.ex_pc); end
    n_cmp++; if (bus.ex_rs1_data !== 64'h0 || bus.ex_imm !== 64'h0) begin n_bad++; $display("FAIL reset_ex_data got %h/%h want 0/0", bus.ex_rs1_data, bus.ex_imm); end
    n_cmp++; if ({bus.ex_rd, bus.ex_rs1, bus.ex_funct} !== 14'h0) begin n_bad++; $display("FAIL reset_ex_regs got %h want 0", {bus.ex_rd, bus.ex_rs1, bus.ex_funct}); end
    n_cmp++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_alu_op} !== 4'h0) begin n_bad++; $display("FAIL reset_ex_ctrl got %h want 0", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_alu_op}); end
    n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", bus.hazard_stall); end
    @(negedge clk);
    reset = 1;
    idle(); bus.id_valid = 1; bus.id_pc = 64'h100; bus.id_rs1_data = 64'hDEAD;
    tick();
    n_cmp++; if (bus.ex_pc !== 64'h100) begin n_bad++; $display("FAIL first_capture_pc got %h want 100", bus.ex_pc); end
    n_cmp++; if (bus.ex_rs1_data !== 64'hDEAD) begin n_bad++; $display("FAIL first_capture_rs1 got %h want dead", bus.ex_rs1_data); end
    n_cmp++; if (bus.ex_valid !== 1'b1) begin n_bad++; $display("FAIL first_capture_valid got %0b want 1", bus.ex_valid); end
  endtask

  task automatic test_load_use();
    @(negedge clk); drive_load(64'h200, 5'd5, 5'd2); tick();
    n_cmp++; if (bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd5) begin n_bad++; $display("FAIL ld_capture got mr=%0b rd=%0d want 1/5", bus.ex_mem_read, bus.ex_rd); end
    @(negedge clk); drive_alu(64'h204, 5'd5, 5'd6, 1, 1); #1;
    n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %0b want 1", bus.hazard_stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble_valid got %0b want 0", bus.ex_valid); end
    n_cmp++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_alu_op} !== 6'h0) begin n_bad++; $display("FAIL lu_bubble_ctrl got %h want 0", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_alu_op}); end
    n_cmp++; if (bus.ex_pc !== 64'h200 || bus.ex_rd !== 5'd5) begin n_bad++; $display("FAIL lu_bubble_hold got pc=%h rd=%0d want 200/5", bus.ex_pc, bus.ex_rd); end
    n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_release got %0b want 0", bus.hazard_stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 64'h204) begin n_bad++; $display("FAIL lu_add_capture got v=%0b pc=%h want 1/204", bus.ex_valid, bus.ex_pc); end
    n_cmp++; if (bus.ex_alu_op !== 2'd2 || bus.ex_funct !== 4'h8) begin n_bad++; $display("FAIL lu_add_ctrl got op=%0d f=%h want 2/8", bus.ex_alu_op, bus.ex_funct); end
  endtask

  task automatic test_x0();
    @(negedge clk); drive_load(64'h300, 5'd0, 5'd1); tick();
    @(negedge clk); drive_alu(64'h304, 5'd0, 5'd0, 1, 1); #1;
    n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL x0_stall got %0b want 0", bus.hazard_stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 64'h304) begin n_bad++; $display("FAIL x0_capture got v=%0b pc=%h want 1/304", bus.ex_valid, bus.ex_pc); end
  endtask

  task automatic test_uses_rs2();
    @(negedge clk); drive_load(64'h400, 5'd7, 5'd1); tick();
    @(negedge clk); drive_alu(64'h404, 5'd3, 5'd7, 1, 0); #1;
    n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL rs2_unused_stall got %0b want 0", bus.hazard_stall); end
    bus.id_uses_rs2 = 1; #1;
    n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL rs2_used_stall got %0b want 1", bus.hazard_stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL rs2_bubble got %0b want 0", bus.ex_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk); drive_load(64'h500, 5'd9, 5'd1); tick();
    @(negedge clk); drive_alu(64'h504, 5'd9, 5'd2, 1, 1); bus.flush = 1; #1;
    n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %0b want 0", bus.hazard_stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_pc !== 64'h500) begin n_bad++; $display("FAIL flush_bubble got v=%0b mr=%0b pc=%h want 0/0/500", bus.ex_valid, bus.ex_mem_read, bus.ex_pc); end
    @(negedge clk); drive_alu(64'h600, 5'd9, 5'd2, 1, 1); tick();
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 64'h600) begin n_bad++; $display("FAIL flush_next got v=%0b pc=%h want 1/600", bus.ex_valid, bus.ex_pc); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive_load(64'h700, 5'd10, 5'd1); tick();
    @(negedge clk); drive_load(64'h704, 5'd11, 5'd1); #1;
    n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_second_ld_stall got %0b want 0", bus.hazard_stall); end
    tick();
    @(negedge clk); drive_alu(64'h708, 5'd10, 5'd11, 1, 0); #1;
    n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_old_ld_stall got %0b want 0", bus.hazard_stall); end
    tick();
    n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 64'h708) begin n_bad++; $display("FAIL b2b_capture got v=%0b pc=%h want 1/708", bus.ex_valid, bus.ex_pc); end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk); drive_load(64'h800, 5'd12, 5'd1); tick();
    @(negedge clk); drive_alu(64'h804, 5'd12, 5'd2, 1, 1); #1;
    n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_bad++; $display("FAIL mid_pre_stall got %0b want 1", bus.hazard_stall); end
    reset = 0; #1;
    n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 64'h0) begin n_bad++; $display("FAIL mid_reset_clear got v=%0b pc=%h want 0/0", bus.ex_valid, bus.ex_pc); end
    n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stall got %0b want 0", bus.hazard_stall); end
    @(negedge clk); reset = 1; idle(); tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 0;
    idle();
    test_reset();
    test_load_use();
    test_x0();
    test_uses_rs2();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register with integrated load-use hazard detection for the 64-bit RISC-V pipeline. It captures the two register-file read operands, the immediate, register addresses and decoded control from the decode stage on each rising clock edge and presents them to the execute stage. It detects a load in EX whose destination feeds the instruction in ID, raises a stall for the fetch/decode stages, and inserts a bubble into EX. A branch-taken flush squashes the instruction being captured.

## Interface
- DATA_W, 64, operand/PC/immediate width
- REG_AW, 5, register address width
- ALUOP_W, 2, ALU-op control width
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low; low clears all EX-side state immediately
- id_valid  input  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  input  DATA_W each  PC, register-file read data 1/2, sign-extended immediate
- id_rs1, id_rs2, id_rd  input  REG_AW each  source/destination register numbers
- id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads that source
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src  input  1 each  decoded control
- id_alu_op  input  ALUOP_W  ALU control class; id_funct  input  4  {funct7[5], funct3}
- flush  input  1  branch taken in EX; squash the ID instruction
- ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src, ex_alu_op, ex_funct  output  matching widths  registered EX-stage copies
- hazard_stall  output  1  combinational; hold PC and IF/ID this cycle

## Operation
- Bubble = ex_valid and all seven control outputs (reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_op) forced to 0; data/address/funct outputs keep previous value.
- hazard_stall = id_valid & !flush & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Per rising edge, priority: flush → bubble; else hazard_stall → bubble (ID instruction retained upstream, re-presented next cycle); else !id_valid → bubble; else capture all id_* into ex_*.
- Register x0 never causes a stall (ex_rd == 0 excluded).
- No arithmetic; widths pass through unchanged.
- Stall lasts exactly one cycle per load-use pair: after the bubble, ex_mem_read = 0 so hazard_stall deasserts.

## Timing
- Latency: one cycle, ID inputs at edge N appear on ex_* after edge N.
- hazard_stall is valid in the same cycle as the ID inputs, no registered delay; upstream samples it at the next rising edge.
- Reset (reset low, asynchronous): every ex_* output = 0, ex_valid = 0, therefore hazard_stall = 0. Deassertion is synchronised externally; first capture on the first rising edge with reset high.
- Reset mid-stall: outputs clear at once, stall drops in the same cycle.
- Flush and hazard in the same cycle: flush wins, hazard_stall = 0, bubble inserted.
- Back-to-back loads with dependent third instruction: stall only against the load currently in EX.

## Structure
- Shared package riscv_pipe_pkg: ctrl_t struct (the seven control fields), CTRL_BUBBLE constant (all zero), DATA_W/REG_AW/ALUOP_W defaults.
- One sub-module: load_use_detect (purely combinational hazard_stall equation), instantiated once; register and priority logic stay in id_ex_register.

## Test plan
- Reset low with random ID inputs → all ex_* = 0, hazard_stall = 0; release, capture id_pc=0x100, id_rs1_data=0xDEAD → ex_pc=0x100, ex_rs1_data=0xDEAD after one edge.
- ld x5 captured (ex_mem_read=1, ex_rd=5), then ID add reading rs1=x5 → hazard_stall=1 that cycle, next edge ex_valid=0 with controls zero, following cycle hazard_stall=0 and add captured.
- Load to x0 followed by instruction reading x0 → hazard_stall=0, no bubble.
- Load with ex_rd=7, ID rs2=7 but id_uses_rs2=0 → no stall.
- flush=1 concurrently with a load-use match → hazard_stall=0, bubble inserted, next valid instruction captured normally.
- Assert reset low mid-stall → ex_valid=0 and hazard_stall=0 before the next rising edge.
